// File: rtl/cpu_hazard_pkg.sv
// Shared hazard-tracking constants and the in-flight record type.
package cpu_hazard_pkg;
  localparam int RW = 5;
  localparam int TW = 2;
  localparam logic [TW-1:0] TUSE_NONE = '1;
  localparam logic [RW-1:0] REG_ZERO  = '0;

  typedef struct packed {
    logic [RW-1:0] dst;
    logic [TW-1:0] tnew;
  } hz_rec_t;

  localparam hz_rec_t REC_BUBBLE = '0;
endpackage

// File: rtl/hazard_port_match.sv
// One D-stage read port: youngest-record match, stall request and forward select.
module hazard_port_match #(
  parameter int STAGES = 3,
  parameter int RW     = cpu_hazard_pkg::RW,
  parameter int TW     = cpu_hazard_pkg::TW,
  parameter int SW     = $clog2(STAGES+1)
) (
  input  logic [STAGES-1:0][RW-1:0] stage_dst,
  input  logic [STAGES-1:0][TW-1:0] stage_tnew,
  input  logic [RW-1:0]             src,
  input  logic [TW-1:0]             tuse,
  output logic                      stall_req,
  output logic [SW-1:0]             fwd_sel
);
  logic          hit;
  logic [TW-1:0] hit_tnew;
  logic [SW-1:0] hit_sel;
  logic          port_used;

  assign port_used = (src != '0) && (tuse != {TW{1'b1}});

  always_comb begin
    hit      = 1'b0;
    hit_tnew = '0;
    hit_sel  = '0;
    // Scan from the youngest stage; the first hit shadows every older one.
    for (int k = 0; k < STAGES; k++) begin
      if (!hit && stage_dst[k] == src) begin
        hit      = 1'b1;
        hit_tnew = stage_tnew[k];
        hit_sel  = SW'(k + 1);
      end
    end
    stall_req = 1'b0;
    fwd_sel   = '0;
    if (port_used && hit) begin
      stall_req = (hit_tnew > tuse);
      if (hit_tnew == '0) fwd_sel = hit_sel;
    end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// Tnew/Tuse scoreboard beside D: record shift register, per-port match, stall OR.
module hazard_scoreboard #(
  parameter  int STAGES = 3,
  parameter  int NRD    = 2,
  parameter  int RW     = cpu_hazard_pkg::RW,
  parameter  int TW     = cpu_hazard_pkg::TW,
  localparam int SW     = $clog2(STAGES+1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 d_valid,
  input  logic [RW-1:0]        d_dst,
  input  logic [TW-1:0]        d_tnew,
  input  logic [NRD*RW-1:0]    d_src,
  input  logic [NRD*TW-1:0]    d_tuse,
  input  logic                 flush_e,
  output logic                 stall,
  output logic [NRD*SW-1:0]    fwd_sel,
  output logic [STAGES*RW-1:0] stage_dst,
  output logic [STAGES*TW-1:0] stage_tnew
);
  logic [STAGES-1:0][RW-1:0] dst_q, dst_d;
  logic [STAGES-1:0][TW-1:0] tnew_q, tnew_d;
  logic [NRD-1:0]            stall_req;

  always_comb begin
    dst_d  = dst_q;
    tnew_d = tnew_q;
    if (stall || flush_e || !d_valid) begin
      dst_d[0]  = '0;
      tnew_d[0] = '0;
    end else begin
      dst_d[0]  = d_dst;
      tnew_d[0] = d_tnew;
    end
    // Older stages shift unconditionally, aging tnew toward zero.
    for (int i = 1; i < STAGES; i++) begin
      dst_d[i]  = dst_q[i-1];
      tnew_d[i] = (tnew_q[i-1] == '0) ? '0 : tnew_q[i-1] - TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dst_q  <= '0;
      tnew_q <= '0;
    end else begin
      dst_q  <= dst_d;
      tnew_q <= tnew_d;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_port
    hazard_port_match #(.STAGES(STAGES), .RW(RW), .TW(TW), .SW(SW)) u_match (
      .stage_dst  (dst_q),
      .stage_tnew (tnew_q),
      .src        (d_src[p*RW +: RW]),
      .tuse       (d_tuse[p*TW +: TW]),
      .stall_req  (stall_req[p]),
      .fwd_sel    (fwd_sel[p*SW +: SW])
    );
  end

  assign stall      = |stall_req;
  assign stage_dst  = dst_q;
  assign stage_tnew = tnew_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scoreboard bench: expectations queued at drive time, popped at sample time.
module tb_hazard_scoreboard;
  logic        clk = 1'b0;
  logic        reset;
  logic        d_valid;
  logic [4:0]  d_dst;
  logic [1:0]  d_tnew;
  logic [9:0]  d_src;
  logic [3:0]  d_tuse;
  logic        flush_e;
  logic        stall;
  logic [3:0]  fwd_sel;
  logic [14:0] stage_dst;
  logic [5:0]  stage_tnew;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_dst(d_dst), .d_tnew(d_tnew),
    .d_src(d_src), .d_tuse(d_tuse), .flush_e(flush_e), .stall(stall),
    .fwd_sel(fwd_sel), .stage_dst(stage_dst), .stage_tnew(stage_tnew)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        st;
    logic [1:0]  f0, f1;
    logic [14:0] sdst;
    logic [5:0]  stnew;
  } exp_t;

  exp_t sb[$];
  int   nchk  = 0;
  int   npass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs === exp) npass++;
    else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [4:0] dst, input logic [1:0] tn,
                       input logic [4:0] s0, input logic [1:0] u0,
                       input logic [4:0] s1, input logic [1:0] u1, input logic fl);
    d_valid = v; d_dst = dst; d_tnew = tn;
    d_src = {s1, s0}; d_tuse = {u1, u0}; flush_e = fl;
  endtask

  // Records given youngest first: (d0,t0)=stage 0 ... (d2,t2)=stage 2.
  task automatic expect_out(input string tag, input logic st, input logic [1:0] f0, input logic [1:0] f1,
                            input logic [4:0] d0, input logic [1:0] t0,
                            input logic [4:0] d1, input logic [1:0] t1,
                            input logic [4:0] d2, input logic [1:0] t2);
    exp_t e;
    e.tag = tag; e.st = st; e.f0 = f0; e.f1 = f1;
    e.sdst = {d2, d1, d0}; e.stnew = {t2, t1, t0};
    sb.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".stall"}, 32'(stall), 32'(e.st));
    chk({e.tag, ".fwd0"},  32'(fwd_sel[1:0]), 32'(e.f0));
    chk({e.tag, ".fwd1"},  32'(fwd_sel[3:2]), 32'(e.f1));
    chk({e.tag, ".sdst"},  32'(stage_dst), 32'(e.sdst));
    chk({e.tag, ".stnew"}, 32'(stage_tnew), 32'(e.stnew));
  endtask

  task automatic cyc();
    #2 sample();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 3, 0, 3, 0);
    expect_out("reset", 0,0,0, 0,0, 0,0, 0,0);
    #2 sample();
    @(negedge clk);
    reset = 1'b1;

    // Producer/consumer: add $8 then reads of $8
    drive(1, 8, 1, 0, 3, 0, 3, 0); expect_out("A", 0,0,0, 0,0, 0,0, 0,0); cyc();
    drive(1, 0, 0, 8, 1, 0, 3, 0); expect_out("B", 0,0,0, 8,1, 0,0, 0,0); cyc();
    drive(1, 0, 0, 8, 1, 0, 3, 0); expect_out("C", 0,2,0, 0,0, 8,0, 0,0); cyc();
    drive(0, 0, 0, 0, 3, 8, 0, 0); expect_out("D", 0,0,3, 0,0, 0,0, 8,0); cyc();
    drive(0, 0, 0, 8, 0, 0, 3, 0); expect_out("E", 0,0,0, 0,0, 0,0, 0,0); cyc();

    // Load-use on $9
    drive(1, 9, 2, 0, 3, 0, 3, 0);  expect_out("F", 0,0,0, 0,0, 0,0, 0,0); cyc();
    drive(1, 10, 1, 9, 0, 0, 3, 0); expect_out("G", 1,0,0, 9,2, 0,0, 0,0); cyc();
    drive(1, 10, 1, 9, 0, 0, 3, 0); expect_out("H", 1,0,0, 0,0, 9,1, 0,0); cyc();
    drive(1, 10, 1, 9, 0, 0, 3, 0); expect_out("I", 0,3,0, 0,0, 0,0, 9,0); cyc();
    drive(0, 0, 0, 0, 3, 0, 3, 0);  expect_out("J", 0,0,0, 10,1, 0,0, 0,0); cyc();

    // Youngest wins: ori $4 in M, lui $4 in E
    drive(1, 4, 1, 0, 3, 0, 3, 0); expect_out("K", 0,0,0, 0,0, 10,0, 0,0); cyc();
    drive(1, 4, 1, 0, 3, 0, 3, 0); expect_out("L", 0,0,0, 4,1, 0,0, 10,0); cyc();
    drive(1, 0, 0, 4, 0, 4, 1, 0); expect_out("M", 1,0,0, 4,1, 4,0, 0,0); cyc();
    drive(1, 0, 0, 4, 0, 0, 3, 0); expect_out("N", 0,2,0, 0,0, 4,0, 4,0); cyc();

    // $0 reads and an unused port naming a live $31
    drive(1, 31, 1, 0, 3, 0, 3, 0); expect_out("O", 0,0,0, 0,0, 0,0, 4,0); cyc();
    drive(1, 0, 1, 0, 3, 0, 3, 0);  expect_out("P", 0,0,0, 31,1, 0,0, 0,0); cyc();
    drive(1, 0, 0, 0, 0, 31, 3, 0); expect_out("Q", 0,0,0, 0,1, 31,0, 0,0); cyc();

    // Flush during stall, then flush alone
    drive(1, 5, 2, 0, 3, 0, 3, 0); expect_out("R", 0,0,0, 0,0, 0,0, 31,0); cyc();
    drive(1, 7, 1, 5, 0, 0, 3, 1); expect_out("S", 1,0,0, 5,2, 0,0, 0,0); cyc();
    drive(1, 7, 1, 0, 3, 0, 3, 0); expect_out("T", 0,0,0, 0,0, 5,1, 0,0);
    d_valid = 1'b0; cyc();
    drive(1, 7, 1, 0, 3, 0, 3, 1); expect_out("U", 0,0,0, 0,0, 0,0, 5,0); cyc();
    drive(0, 0, 0, 0, 3, 0, 3, 0); expect_out("V", 0,0,0, 0,0, 0,0, 0,0); cyc();

    // Async reset with live records
    drive(1, 12, 2, 0, 3, 0, 3, 0);  expect_out("W", 0,0,0, 0,0, 0,0, 0,0); cyc();
    drive(1, 13, 1, 12, 0, 0, 3, 0); expect_out("X_live", 1,0,0, 12,2, 0,0, 0,0);
    #2 sample();
    #1 reset = 1'b0;
    expect_out("X_rst", 0,0,0, 0,0, 0,0, 0,0);
    #1 sample();
    @(negedge clk);
    reset = 1'b1;
    drive(1, 14, 1, 0, 3, 0, 3, 0); expect_out("Y", 0,0,0, 0,0, 0,0, 0,0); cyc();
    drive(0, 0, 0, 0, 3, 0, 3, 0);  expect_out("Z", 0,0,0, 14,1, 0,0, 0,0); cyc();

    if (sb.size() != 0) chk("sb_leftover", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised Tnew/Tuse scoreboard that replaces the per-stage combinational hazard decoders in the pipelined MIPS core. It sits beside the D-stage and keeps a shift register of (destination, Tnew) records for every instruction in flight past D. Each cycle it ages the records and compares them against the D-stage source registers. From that it produces the D-stage stall, a forwarding select per read port, and per-stage records for downstream forwarding muxes.

## Interface
Parameters:
- STAGES, 3: tracked stages after D (index 0 = E, 1 = M, 2 = W, ...).
- NRD, 2: D-stage read ports (rs, rt, ...).
- RW, 5: register address width.
- TW, 2: Tnew/Tuse width. Tuse value all-ones = port not used.
- SW, derived $clog2(STAGES+1): forwarding select width.

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-low; clears every record.
- d_valid, in, 1: D holds a real instruction.
- d_dst, in, RW: D destination register; 0 means none.
- d_tnew, in, TW: cycles after entering E until the result exists.
- d_src, in, NRD*RW: packed D source registers.
- d_tuse, in, NRD*TW: packed Tuse per source.
- flush_e, in, 1: kill the instruction entering E this cycle.
- stall, out, 1: hold F/D, insert a bubble into E.
- fwd_sel, out, NRD*SW: per port, 0 = register file, k+1 = forward from stage k.
- stage_dst, out, STAGES*RW: current record destination per stage.
- stage_tnew, out, STAGES*TW: current record Tnew per stage.

## Operation
- Record = {dst, tnew}. Bubble = {0, 0}.
- Stage 0 load:
  - Bubble if stall, flush_e, or !d_valid.
  - Otherwise {d_dst, d_tnew}.
  - flush_e and stall together: bubble; no other effect.
- Stage i>0 load: record of stage i-1 with tnew decremented, saturating at 0. This shifts every cycle, including during stall.
- Match per port p with src = d_src[p]:
  - src == 0, or d_tuse[p] all-ones: no match; fwd_sel = 0; the port contributes no stall.
  - Otherwise the youngest stage k (lowest index) with stage_dst[k] == src wins. Older matches are ignored.
  - Winner with tnew > tuse: port requests stall.
  - Winner with tnew == 0: fwd_sel = k+1.
  - Winner with 0 < tnew ≤ tuse: fwd_sel = 0. The later-stage forward uses stage_dst/stage_tnew.
  - No winner: fwd_sel = 0.
- stall = OR of all port requests.
- Records with dst == 0 never match, so bubbles and non-writing instructions are inert.

## Timing
- stall and fwd_sel: purely combinational from the current records and D inputs, same cycle.
- Records: update on the rising clk edge. An instruction accepted in cycle n appears in stage 0 in cycle n+1 and in stage k in cycle n+1+k.
- Reset asserted, including mid-stream: every record is a bubble immediately. stall = 0 and fwd_sel = 0 unless the D inputs still match a nonzero dst (none exists). Deassertion takes effect at the next clk edge.
- After reset release, the first valid D instruction loads at the first edge.
- No record survives past stage STAGES-1.

## Structure
- Shared package cpu_hazard_pkg holds:
  - constants RW, TW, TUSE_NONE (all-ones), REG_ZERO;
  - the record typedef and the bubble constant.
- Sub-module hazard_port_match is instantiated NRD times. It takes the record vector, src, and tuse, and returns {stall_req, fwd_sel} using a priority scan from stage 0.
- Top level holds the record shift register and the stall OR.

## Test plan
1. Producer/consumer, no stall:
   - Stimulus: D issues add $8 (tnew 1); next cycle D reads $8 with tuse 1.
   - Required: stall = 0, fwd_sel = 0.
   - Following cycle (add now in M, tnew 0) with the same read: fwd_sel = 2.
2. Load-use:
   - Stimulus: lw $9 (tnew 2) enters E; D reads $9 with tuse 0.
   - Required: stall = 1 for 2 cycles, stage 0 is a bubble each time; then fwd_sel = 3 (W) with stall = 0.
3. Youngest wins:
   - Stimulus: ori $4 in M (tnew 0) and lui $4 in E (tnew 1); D reads $4 with tuse 0.
   - Required: stall = 1. The M match is ignored.
4. $0 and unused port:
   - Stimulus: jal-style record with dst 31 and an ori to $0 in flight; D reads $0, and a port with tuse 3 reads $31.
   - Required: stall = 0, fwd_sel = 0 on both ports.
5. Flush during stall:
   - Stimulus: flush_e = 1 and stall = 1 together with d_valid = 1, d_dst = 7.
   - Required: stage 0 = {0, 0} next cycle; older records still shift.
6. Async reset:
   - Stimulus: drive reset low between edges while records are live.
   - Required: stage_dst/stage_tnew = 0 immediately, stall = 0; recovery on the first edge after release.
